// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the F/D pipeline register.
// Owns the PC, requests words from instruction memory and holds one
// fetched word until decode accepts it.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall               decode cannot accept the presented word
//   redirect_valid/     taken branch/jump and its target PC
//   redirect_target
//   halt                stop issuing requests once the buffer drains
//   imem_req/addr       fetch request and word address (the PC)
//   imem_ready/rdata    memory completion and returned instruction
//   pc_value_next       PC+4 of the presented instruction
//   next_instruction    word presented to the F/D register
//   flush               F/D register must load a bubble this cycle
//   halted              fetch is parked in the halt state
//   fetch_count         number of words accepted by decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_value_next,
    output logic [31:0] next_instruction,
    output logic        flush,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pcnext_q, buf_pcnext_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        req;
    logic        fill;
    logic        consume;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = redirect_target & ~32'h3;

    // A request is only made when the buffer is free or will be freed
    // this cycle; reset masks it so a stale state cannot start a fetch.
    always_comb begin
        req     = (state_q == S_FETCH) && !redirect_valid && !halt
                  && (!buf_valid_q || !stall) && !reset;
        fill    = req && imem_ready;
        consume = buf_valid_q && !stall && !redirect_valid;
    end

    assign imem_req         = req;
    assign imem_addr        = pc_q;
    assign next_instruction = buf_valid_q ? buf_instr_q : NOP_INSTR;
    assign pc_value_next    = buf_pcnext_q;
    assign flush            = reset || redirect_valid
                              || (!buf_valid_q && !stall);
    assign halted           = (state_q == S_HALT) && !reset;
    assign fetch_count      = fetch_count_q;

    // Control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!redirect_valid && halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // PC, buffer and delivery counter
    always_comb begin
        pc_d          = pc_q;
        buf_valid_d   = buf_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_pcnext_d  = buf_pcnext_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d        = target_aligned;
            buf_valid_d = 1'b0;
        end else begin
            if (consume) begin
                fetch_count_d = fetch_count_q + 32'd1;
            end
            // A fill in the same cycle as a consume overwrites the
            // outgoing word, sustaining one instruction per cycle.
            if (fill) begin
                buf_valid_d  = 1'b1;
                buf_instr_d  = imem_rdata;
                buf_pcnext_d = pc_plus4;
                pc_d         = pc_plus4;
            end else if (consume) begin
                buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT;
            pc_q          <= RESET_PC;
            buf_valid_q   <= 1'b0;
            buf_instr_q   <= NOP_INSTR;
            buf_pcnext_q  <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_valid_q   <= buf_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pcnext_q  <= buf_pcnext_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked
// against an in-order delivery scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_value_next;
    logic [31:0] next_instruction;
    logic        flush;
    logic        halted;
    logic [31:0] fetch_count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt;

    localparam logic [31:0] NOP = 32'h2000_0000;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = word(imem_addr);

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .halt             (halt),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .pc_value_next    (pc_value_next),
        .next_instruction (next_instruction),
        .flush            (flush),
        .halted           (halted),
        .fetch_count      (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt = 1'b0; imem_ready = 1'b1;
        tick();
        tick();
        settle();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rst_flush got=%b exp=1", flush); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
        reset = 1'b0;
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL c0_flush got=%b exp=1", flush); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL c0_req got=%b exp=0", imem_req); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL c0_count got=%0d exp=0", fetch_count); end
        checks++; if (next_instruction !== NOP) begin failures++; $display("FAIL c0_instr got=%h exp=%h", next_instruction, NOP); end
        checks++; if (pc_value_next !== 32'h0) begin failures++; $display("FAIL c0_pcn got=%h exp=0", pc_value_next); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_stream_stall();
        tick();
        settle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL c1_req got=%b/%h exp=1/0", imem_req, imem_addr); end
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL c1_flush got=%b exp=1", flush); end
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            checks++; if (next_instruction !== word(32'(4 * i))) begin failures++; $display("FAIL stream_instr%0d got=%h exp=%h", i, next_instruction, word(32'(4 * i))); end
            checks++; if (pc_value_next !== 32'(4 * i + 4)) begin failures++; $display("FAIL stream_pcn%0d got=%h exp=%h", i, pc_value_next, 32'(4 * i + 4)); end
            checks++; if (flush !== 1'b0 || imem_addr !== 32'(4 * i + 4)) begin failures++; $display("FAIL stream_addr%0d got=%b/%h exp=0/%h", i, flush, imem_addr, 32'(4 * i + 4)); end
            checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL stream_count%0d got=%0d exp=%0d", i, fetch_count, exp_cnt); end
            exp_cnt++;
        end
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (next_instruction !== word(32'h8) || pc_value_next !== 32'hC) begin failures++; $display("FAIL stall_hold%0d got=%h/%h exp=%h/c", i, next_instruction, pc_value_next, word(32'h8)); end
            checks++; if (flush !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_ctl%0d got=%b/%b exp=0/0", i, flush, imem_req); end
            checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL stall_count%0d got=%0d exp=%0d", i, fetch_count, exp_cnt); end
            tick();
        end
        stall = 1'b0;
        settle();
        checks++; if (next_instruction !== word(32'h8) || flush !== 1'b0) begin failures++; $display("FAIL unstall_instr got=%h exp=%h", next_instruction, word(32'h8)); end
        exp_cnt++;
        tick();
        settle();
        checks++; if (next_instruction !== word(32'hC) || pc_value_next !== 32'h10) begin failures++; $display("FAIL resume_instr got=%h/%h exp=%h/10", next_instruction, pc_value_next, word(32'hC)); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL count3 got=%0d exp=3", fetch_count); end
        exp_cnt++;
    endtask

    task automatic test_redirect();
        tick();
        settle();
        checks++; if (next_instruction !== word(32'h10)) begin failures++; $display("FAIL pre_redir_instr got=%h exp=%h", next_instruction, word(32'h10)); end
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        settle();
        checks++; if (flush !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_ctl got=%b/%b exp=1/0", flush, imem_req); end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL redir_addr got=%h/%b exp=100/1", imem_addr, imem_req); end
        checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL redir_count got=%0d exp=%0d", fetch_count, exp_cnt); end
        tick();
        settle();
        checks++; if (next_instruction !== word(32'h100) || pc_value_next !== 32'h104) begin failures++; $display("FAIL redir_deliver got=%h/%h exp=%h/104", next_instruction, pc_value_next, word(32'h100)); end
        exp_cnt++;
    endtask

    task automatic test_wait_states();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        settle();
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic        exp_flush;
            logic [31:0] exp_addr;
            imem_ready = (i % 3 == 2);
            exp_flush = !(i >= 3 && i % 3 == 0);
            exp_addr = 32'h200 + 32'(4 * (i / 3));
            settle();
            checks++; if (flush !== exp_flush) begin failures++; $display("FAIL wait_flush%0d got=%b exp=%b", i, flush, exp_flush); end
            checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL wait_addr%0d got=%h exp=%h", i, imem_addr, exp_addr); end
            checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL wait_count%0d got=%0d exp=%0d", i, fetch_count, exp_cnt); end
            if (!exp_flush) begin
                checks++; if (next_instruction !== word(exp_addr - 32'd4)) begin failures++; $display("FAIL wait_instr%0d got=%h exp=%h", i, next_instruction, word(exp_addr - 32'd4)); end
                exp_cnt++;
            end
            tick();
        end
        imem_ready = 1'b1;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        settle();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL wrap_flush got=%b exp=1", flush); end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        tick();
        settle();
        checks++; if (pc_value_next !== 32'h0 || next_instruction !== word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_pcn got=%h/%h exp=0/%h", pc_value_next, next_instruction, word(32'hFFFF_FFFC)); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=0", imem_addr); end
        exp_cnt++;
    endtask

    task automatic test_halt();
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        settle();
        tick();
        redirect_valid = 1'b0;
        settle();
        tick();
        halt = 1'b1;
        settle();
        checks++; if (next_instruction !== word(32'h20) || flush !== 1'b0) begin failures++; $display("FAIL halt_deliver got=%h/%b exp=%h/0", next_instruction, flush, word(32'h20)); end
        checks++; if (imem_req !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL halt_first got=%b/%b exp=0/0", imem_req, halted); end
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || flush !== 1'b1) begin failures++; $display("FAIL halted%0d got=%b/%b/%b exp=1/0/1", i, halted, imem_req, flush); end
            checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL halt_count%0d got=%0d exp=%0d", i, fetch_count, exp_cnt); end
        end
        tick();
        halt = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        settle();
        checks++; if (flush !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL unhalt_redir got=%b/%b exp=1/0", flush, imem_req); end
        tick();
        redirect_valid = 1'b0;
        settle();
        checks++; if (halted !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin failures++; $display("FAIL resume_fetch got=%b/%h/%b exp=0/40/1", halted, imem_addr, imem_req); end
        tick();
        settle();
        checks++; if (next_instruction !== word(32'h40) || pc_value_next !== 32'h44) begin failures++; $display("FAIL resume_deliver got=%h/%h exp=%h/44", next_instruction, pc_value_next, word(32'h40)); end
        exp_cnt++;
    endtask

    // Scoreboard view: decode must see the program in order from the
    // last reset/redirect target, one word per accepted cycle.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          delivered;
        exp_pc = 32'h0;
        delivered = 0;
        halt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = (c == 0 || c == 1200);
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_target = $urandom;
            halt = ($urandom_range(0, 39) == 0) ? 1'b1 : (halt && $urandom_range(0, 7) != 0);
            imem_ready = ($urandom_range(0, 4) < 3);
            settle();
            if (reset) begin
                checks++; if (imem_req !== 1'b0 || flush !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL rnd_reset%0d got=%b/%b/%b exp=0/1/0", c, imem_req, flush, halted); end
                exp_pc = 32'h0;
                exp_cnt = 32'd0;
            end else begin
                checks++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL rnd_count%0d got=%0d exp=%0d", c, fetch_count, exp_cnt); end
                if (imem_req) begin
                    checks++; if (imem_addr !== exp_pc && imem_addr !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_addr%0d got=%h exp=%h", c, imem_addr, exp_pc); end
                end
                if (halted) begin
                    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rnd_halt_req%0d got=%b exp=0", c, imem_req); end
                end
                if (redirect_valid) begin
                    checks++; if (flush !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL rnd_redir%0d got=%b/%b exp=1/0", c, flush, imem_req); end
                    exp_pc = redirect_target & ~32'h3;
                end else if (stall) begin
                    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rnd_stall_flush%0d got=%b exp=0", c, flush); end
                end else if (!flush) begin
                    checks++; if (next_instruction !== word(exp_pc) || pc_value_next !== exp_pc + 32'd4) begin failures++; $display("FAIL rnd_deliver%0d got=%h/%h exp=%h/%h", c, next_instruction, pc_value_next, word(exp_pc), exp_pc + 32'd4); end
                    exp_pc = exp_pc + 32'd4;
                    exp_cnt++;
                    delivered++;
                end
            end
        end
        checks++; if (delivered < 200) begin failures++; $display("FAIL rnd_progress got=%0d exp>=200", delivered); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream_stall();
        test_redirect();
        test_wait_states();
        test_wrap();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and producer side of the fetch/decode interface.
- Owns the program counter and issues requests to instruction memory.
- Buffers one fetched word and drives the `pc_value_next`, `next_instruction` and `flush` inputs of the F/D pipeline register.
- Handles decode-stage stalls, branch/jump redirects and halt.

Parameters:
- RESET_PC, 32'h00000000, PC value after reset.
- NOP_INSTR, 32'h20000000, bubble word (addi $0,$0,0) presented when no valid instruction is available.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept this cycle; outputs and PC held.
- redirect_valid  input  1  branch/jump taken; discard wrong-path state.
- redirect_target  input  32  new PC when redirect_valid.
- halt  input  1  stop fetching after the current buffered word.
- imem_req  output  1  fetch request for imem_addr.
- imem_addr  output  32  word address (PC); bits[1:0] always 0.
- imem_ready  input  1  memory has data for imem_addr this cycle.
- imem_rdata  input  32  instruction word; valid when imem_req && imem_ready.
- pc_value_next  output  32  PC+4 of the presented instruction.
- next_instruction  output  32  instruction presented to the F/D register.
- flush  output  1  F/D register must load NOP_INSTR this cycle.
- halted  output  1  high in HALT state.
- fetch_count  output  32  instructions delivered to decode; wraps at 2^32.

Behaviour:
- State: FSM {S_INIT, S_FETCH, S_HALT}; `pc_q`[31:0]; one-entry buffer `buf_valid`, `buf_instr`, `buf_pcnext`; `fetch_count`.
- Reset (sync, takes priority over all other inputs):
  - state=S_INIT, pc_q=RESET_PC, buf_valid=0, buf_instr=NOP_INSTR, buf_pcnext=RESET_PC, fetch_count=0.
  - Output values during and after the reset cycle: imem_req=0, flush=1, halted=0.
- S_INIT: one cycle with no request, then unconditionally to S_FETCH. A redirect in S_INIT loads pc_q and is otherwise ignored.
- Memory handshake:
  - A transaction completes in any cycle with imem_req && imem_ready.
  - imem_req may drop without completing; memory restarts on address change.
  - imem_addr = pc_q (combinational).
  - imem_req = (state==S_FETCH) && !redirect_valid && !halt && (!buf_valid || !stall).
- Presentation (combinational):
  - next_instruction = buf_valid ? buf_instr : NOP_INSTR.
  - pc_value_next = buf_pcnext.
  - flush = redirect_valid || (!buf_valid && !stall).
- Consumption: the buffered word is consumed on any cycle with buf_valid && !stall && !redirect_valid. fetch_count increments by 1 on each consumption.
- Fill:
  - On handshake completion: buf_instr <= imem_rdata, buf_pcnext <= pc_q+4, buf_valid <= 1, pc_q <= pc_q+4.
  - Consumption and fill in the same cycle: the new word replaces the old. One instruction per cycle sustained with zero-wait memory.
  - Consumption without fill: buf_valid <= 0.
- Stall (stall=1, no redirect):
  - pc_q, buffer and fetch_count are unchanged; outputs hold their values; flush=0.
  - If the buffer is empty, imem_req may still fill it.
- Redirect (highest priority after reset, in any state):
  - pc_q <= redirect_target, buf_valid <= 0, flush=1 that cycle, imem_req=0.
  - No consumption count, even if stall is also asserted.
  - In S_HALT, a redirect returns the FSM to S_FETCH.
- Halt:
  - In S_FETCH with halt=1 and no redirect, the FSM goes to S_HALT next cycle.
  - A valid buffered word is still delivered (consumed normally); no new requests are issued.
  - S_HALT: imem_req=0, halted=1, flush=1 once the buffer is empty. Exit only via redirect or reset.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFFFFFC wraps to 0 with no error. redirect_target bits[1:0] are forced to 0 when loaded.
- Reset mid-operation: reset in any cycle discards the buffer and any in-progress memory transaction.

Test Plan:
- Reset then zero-wait memory returning PC-indexed words:
  - Cycle 0 after reset: flush=1, no request.
  - From cycle 1: imem_addr 0,4,8…; from cycle 2: next_instruction is the word at 0, pc_value_next=4, one per cycle; fetch_count=3 after three deliveries.
- Stall for 3 cycles while word@8 is buffered:
  - next_instruction and pc_value_next (=12) held; flush=0; imem_req=0; fetch_count unchanged.
  - Resumes with word@12 next.
- redirect_valid with target 32'h00000100 while word@0x10 is buffered:
  - flush=1 that cycle; word@0x10 is never delivered.
  - Next imem_addr=0x100; delivered pc_value_next=0x104.
- Memory with 2-cycle wait (imem_ready every third cycle): flush=1 in each empty cycle, no duplicate or skipped PCs.
- Redirect to 32'hFFFFFFFC: delivered pc_value_next=0; next imem_addr=0.
- halt asserted with word@0x20 buffered:
  - word@0x20 delivered; halted=1 next cycle; imem_req stays 0 and flush=1 thereafter.
  - Redirect to 0x40 resumes fetch at 0x40.
